// File: rtl/w_schedule_gen.sv
// w_schedule_gen: SHA-2 message schedule, streams W_0..W_{ROUNDS-1} from one block
// using a 16-word circular buffer rewritten in place as each word retires.
module w_schedule_gen #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [16*WORD_W-1:0]  m_block,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WORD_W-1:0]     w_data,
    output logic [6:0]            w_idx,
    output logic                  w_last,
    output logic                  busy
);
    localparam int S0A = (WORD_W == 32) ? 7 : 1;
    localparam int S0B = (WORD_W == 32) ? 18 : 8;
    localparam int S0C = (WORD_W == 32) ? 3 : 7;
    localparam int S1A = (WORD_W == 32) ? 17 : 19;
    localparam int S1B = (WORD_W == 32) ? 19 : 61;
    localparam int S1C = (WORD_W == 32) ? 10 : 6;
    localparam logic [6:0] LAST = 7'(ROUNDS - 1);
    localparam logic [7:0] R8 = 8'(ROUNDS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [6:0]        t;
    logic [WORD_W-1:0] mem [16];
    logic [WORD_W-1:0] w_new;
    logic [3:0]        i0, i1, i9, i14;
    logic              accept, fire;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0A) ^ rotr(x, S0B) ^ (x >> S0C);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1A) ^ rotr(x, S1B) ^ (x >> S1C);
    endfunction

    always_comb begin
        i0      = t[3:0];
        i1      = i0 + 4'd1;
        i9      = i0 + 4'd9;
        i14     = i0 + 4'd14;
        busy    = state == RUN;
        m_ready = !busy;
        w_valid = busy;
        w_data  = busy ? mem[i0] : '0;
        w_idx   = busy ? t : '0;
        w_last  = busy && t == LAST;
        accept  = m_ready && m_valid;
        fire    = w_valid && w_ready;
        w_new   = sig1(mem[i14]) + mem[i9] + sig0(mem[i1]) + mem[i0];
        state_n = accept ? RUN : (fire && w_last) ? IDLE : state;
    end

    // The slot of W_t is free once W_t retires, so W_{t+16} lands there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            for (int j = 0; j < 16; j++) mem[j] <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                for (int j = 0; j < 16; j++) mem[j] <= m_block[(15-j)*WORD_W +: WORD_W];
                t <= '0;
            end else if (fire) begin
                if (({1'b0, t} + 8'd16) < R8) mem[i0] <= w_new;
                if (t != LAST) t <= t + 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_w_schedule_gen.sv
// tb_w_schedule_gen: random and directed stimulus against a full-schedule reference
// model (standard W_t recurrence over a 128-entry array) for SHA-256 and SHA-512 builds.
module tb_w_schedule_gen;
    logic clk = 0;
    always #5 clk = ~clk;
    logic reset = 1;

    logic         m_valid = 0, m_ready, w_valid, w_ready = 1, w_last, busy;
    logic [511:0] m_block = '0;
    logic [31:0]  w_data;
    logic [6:0]   w_idx;

    logic          m_valid64 = 0, m_ready64, w_valid64, w_ready64 = 1, w_last64, busy64;
    logic [1023:0] m_block64 = '0;
    logic [63:0]   w_data64;
    logic [6:0]    w_idx64;

    w_schedule_gen #(.WORD_W(32), .ROUNDS(64)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_ready(m_ready), .m_block(m_block),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
        .w_last(w_last), .busy(busy));

    w_schedule_gen #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk(clk), .reset(reset), .m_valid(m_valid64), .m_ready(m_ready64), .m_block(m_block64),
        .w_valid(w_valid64), .w_ready(w_ready64), .w_data(w_data64), .w_idx(w_idx64),
        .w_last(w_last64), .busy(busy64));

    int n_tests = 0, n_fail = 0, cyc = 0;
    int nwords = 0, nlast = 0, naccept = 0, last_idx = 0, last_cyc = 0, acc_cyc = 0;
    int n64 = 0, nlast64 = 0, last64 = 0, e64 = 0;
    bit chk = 0, stall_prev = 0, mrun = 0;
    int mt = 0;
    logic [31:0] prev_data;
    logic [6:0]  prev_idx;
    logic [63:0] sched32 [128], sched64 [128], got [128], ref32 [128], got64 [128];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
        logic [31:0] y;
        y = x[31:0];
        return (w == 32) ? {32'h0, (y >> n) | (y << (32 - n))} : (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] s0(input logic [63:0] x, input int w);
        return (w == 32) ? rr(x, 7, w) ^ rr(x, 18, w) ^ (x >> 3) : rr(x, 1, w) ^ rr(x, 8, w) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] s1(input logic [63:0] x, input int w);
        return (w == 32) ? rr(x, 17, w) ^ rr(x, 19, w) ^ (x >> 10) : rr(x, 19, w) ^ rr(x, 61, w) ^ (x >> 6);
    endfunction

    task automatic fill32(input logic [511:0] b);
        for (int j = 0; j < 16; j++) sched32[j] = {32'h0, b[(15-j)*32 +: 32]};
        for (int j = 16; j < 64; j++)
            sched32[j] = (s1(sched32[j-2], 32) + sched32[j-7] + s0(sched32[j-15], 32) + sched32[j-16]) & 64'hFFFF_FFFF;
    endtask

    task automatic fill64(input logic [1023:0] b);
        for (int j = 0; j < 16; j++) sched64[j] = b[(15-j)*64 +: 64];
        for (int j = 16; j < 80; j++)
            sched64[j] = s1(sched64[j-2], 64) + sched64[j-7] + s0(sched64[j-15], 64) + sched64[j-16];
    endtask

    // Compare DUT against the model state, then advance the model from the inputs
    // that the coming rising edge will sample.
    always @(negedge clk) begin
        cyc++;
        if (chk) begin
            check("m_ready", m_ready, !mrun);
            check("busy", busy, mrun);
            check("w_valid", w_valid, mrun);
            check("w_data", w_data, mrun ? sched32[mt] : 64'h0);
            check("w_last", w_last, mrun && mt == 63);
            if (mrun) check("w_idx", w_idx, mt);
            if (stall_prev) begin
                check("stall_data", w_data, prev_data);
                check("stall_idx", w_idx, prev_idx);
            end
        end
        stall_prev = chk && !reset && w_valid && !w_ready;
        prev_data  = w_data;
        prev_idx   = w_idx;
        if (w_valid && w_ready && !reset) begin
            got[w_idx] = w_data;
            nwords++;
            if (w_last) begin nlast++; last_idx = w_idx; last_cyc = cyc; end
        end
        if (m_valid && m_ready && !reset) begin naccept++; acc_cyc = cyc; end
        if (reset) begin mrun = 0; mt = 0; end
        else if (!mrun && m_valid) begin mrun = 1; mt = 0; fill32(m_block); end
        else if (mrun && w_ready) begin if (mt == 63) mrun = 0; else mt++; end
    end

    always @(negedge clk) begin
        if (chk && w_valid64 && w_ready64) begin
            check("w64_data", w_data64, sched64[e64]);
            check("w64_idx", w_idx64, e64);
            got64[w_idx64] = w_data64;
            e64++;
            n64++;
            if (w_last64) begin nlast64++; last64 = w_idx64; end
        end
    end

    task automatic wait_accept(input int na, input string nm);
        int k = 0;
        while (naccept == na && k < 200) begin @(posedge clk); #1; k++; end
        check(nm, k < 200, 1);
    endtask

    task automatic wait_last(input int nl, input bit rnd, input string nm);
        int k = 0;
        while (nlast == nl && k < 1000) begin
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1; k++;
        end
        w_ready = 1;
        check(nm, k < 1000, 1);
    endtask

    task automatic run32(input logic [511:0] b, input bit rnd);
        int na, nl, nw;
        na = naccept; nl = nlast; nw = nwords;
        m_block = b; m_valid = 1;
        wait_accept(na, "accept_timeout");
        m_valid = 0;
        wait_last(nl, rnd, "done_timeout");
        check("word_count", nwords - nw, 64);
        check("last_idx", last_idx, 63);
    endtask

    function automatic logic [511:0] rnd_block();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[j*32 +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [511:0]  abc, ba, bb;
        logic [1023:0] abc64;
        int na, nl, la, nz, nd, k;
        abc   = {32'h61626380, 448'h0, 32'h00000018};
        abc64 = {64'h6162638000000000, 896'h0, 64'h18};
        fill32(abc);
        check("model_w16", sched32[16], 64'h61626380);
        check("model_w17", sched32[17], 64'h000F0000);
        fill64(abc64);
        check("model64_w16", sched64[16], 64'h6162638000000000);
        check("model64_w17", sched64[17], 64'h00030000000000C0);
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk = 1;
        @(negedge clk);
        check("rst_m_ready", m_ready, 1);
        check("rst_w_valid", w_valid, 0);
        check("rst_w_data", w_data, 0);
        check("rst_w_idx", w_idx, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;

        run32(abc, 0);
        check("abc_w0", got[0], 64'h61626380);
        check("abc_w15", got[15], 64'h18);
        check("abc_w16", got[16], 64'h61626380);
        check("abc_w17", got[17], 64'h000F0000);
        for (int j = 0; j < 64; j++) ref32[j] = got[j];

        run32(abc, 1);
        nd = 0;
        for (int j = 0; j < 64; j++) if (got[j] !== ref32[j]) nd++;
        check("bp_same_seq", nd, 0);

        ba = rnd_block(); bb = rnd_block();
        na = naccept; m_block = ba; m_valid = 1;
        wait_accept(na, "b2b_acc1");
        m_block = bb; na = naccept; nl = nlast;
        wait_last(nl, 0, "b2b_last1");
        la = last_cyc;
        wait_accept(na, "b2b_acc2");
        check("b2b_gap", acc_cyc - la, 1);
        m_valid = 0; nl = nlast;
        wait_last(nl, 1, "b2b_last2");

        na = naccept; m_block = '0; m_valid = 1;
        wait_accept(na, "zero_acc");
        m_block = rnd_block(); na = naccept; nl = nlast;
        wait_last(nl, 1, "zero_last");
        la = last_cyc;
        nz = 0;
        for (int j = 0; j < 64; j++) if (got[j] != 0) nz++;
        check("zero_words", nz, 0);
        check("run_mvalid_ignored", naccept - na, 0);
        wait_accept(na, "zero_next_acc");
        check("idle_accept_gap", acc_cyc - la, 1);
        m_valid = 0; nl = nlast;
        wait_last(nl, 1, "zero_next_last");

        for (int r = 0; r < 4; r++) run32(rnd_block(), 1);

        na = naccept; m_block = rnd_block(); m_valid = 1;
        wait_accept(na, "rst_acc");
        m_valid = 0; w_ready = 1; k = 0;
        while (w_idx != 7'd30 && k < 100) begin @(posedge clk); #1; k++; end
        check("rst_reach_t30", w_idx, 30);
        nl = nlast;
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("midrst_w_valid", w_valid, 0);
        check("midrst_w_data", w_data, 0);
        check("midrst_w_idx", w_idx, 0);
        check("midrst_m_ready", m_ready, 1);
        repeat (5) @(posedge clk);
        #1 check("midrst_no_last", nlast - nl, 0);
        run32(rnd_block(), 1);

        m_block64 = abc64; m_valid64 = 1; k = 0;
        while (!m_ready64 && k < 10) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1 m_valid64 = 0;
        k = 0;
        while (nlast64 == 0 && k < 200) begin @(posedge clk); #1; k++; end
        check("w64_done", nlast64, 1);
        check("w64_count", n64, 80);
        check("w64_last_idx", last64, 79);
        check("w64_w16", got64[16], 64'h6162638000000000);
        check("w64_w17", got64[17], 64'h00030000000000C0);
        repeat (3) @(posedge clk);
        #1 check("w64_idle", m_ready64, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
